// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encoding used by the register bank and the
// execute stage, plus the execute-stage FSM state encoding.
package alu_pkg;

  localparam int DEFAULT_DATA_W = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/result bus of the ALU execute stage. The flags signal exists only
// when ALU_EXEC_FLAGS_EN is defined.
interface alu_exec_if #(parameter int DATA_W = 3);

  localparam int RES_W = 2 * DATA_W;

  // start is a one-cycle request, honoured only while busy is low. The result
  // transfers on a rising edge where result_valid && result_ready are both 1;
  // result (and flags) hold steady from result_valid rising until that edge.
  logic              start;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [1:0]        compute;
  logic              busy;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
`ifdef ALU_EXEC_FLAGS_EN
  logic [1:0]        flags;
`endif

  modport master (
    output start, data_a, data_b, compute, result_ready,
    input  busy, result, result_valid
`ifdef ALU_EXEC_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  start, data_a, data_b, compute, result_ready,
    output busy, result, result_valid
`ifdef ALU_EXEC_FLAGS_EN
    , output flags
`endif
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per step, DATA_W steps.
// product is the accumulator value as it will be after the current step.
module alu_mul_seq #(
  parameter int DATA_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  last
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CNT_W-1:0] idx;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] addend;

  always_comb begin
    addend = '0;
    if (b[idx]) addend = RES_W'(a) << idx;
  end

  assign product = acc + addend;
  assign last    = (idx == CNT_W'(DATA_W - 1));

  // idx returns to 0 after the final step so b is never indexed past its MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
    end else if (clear) begin
      acc <= '0;
      idx <= '0;
    end else if (step) begin
      acc <= product;
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Sequenced ALU execute stage: ADD/SUB/AND in one cycle, MUL over DATA_W
// cycles, result offered on a valid/ready handshake. Optional ALU_EXEC_FLAGS_EN.
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  alu_exec_if.slave    bus,
  output state_e       fsm_state
);

  localparam int RES_W = 2 * DATA_W;

  state_e            state, state_next;
  logic [DATA_W-1:0] a_q, b_q;
  op_e               op_q;
  logic [RES_W-1:0]  res_q, res_next;
  logic [RES_W-1:0]  a_ext, b_ext;
  logic              latch, load_res;
  logic              mul_clear, mul_step, mul_last;
  logic [RES_W-1:0]  mul_product;

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .clear   (mul_clear),
    .step    (mul_step),
    .a       (a_q),
    .b       (b_q),
    .product (mul_product),
    .last    (mul_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    load_res   = 1'b0;
    mul_clear  = 1'b0;
    mul_step   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch = 1'b1;
          if (bus.compute == OP_MUL) begin
            mul_clear  = 1'b1;
            state_next = MUL;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        load_res   = 1'b1;
        state_next = DONE;
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          load_res   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands widen to RES_W first so SUB wraps modulo 2^RES_W.
  always_comb begin
    a_ext    = RES_W'(a_q);
    b_ext    = RES_W'(b_q);
    res_next = '0;
    case (op_q)
      OP_ADD:  res_next = a_ext + b_ext;
      OP_SUB:  res_next = a_ext - b_ext;
      OP_AND:  res_next = a_ext & b_ext;
      default: res_next = mul_product;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      res_q <= '0;
    end else begin
      if (latch) begin
        a_q  <= bus.data_a;
        b_q  <= bus.data_b;
        op_q <= op_e'(bus.compute);
      end
      if (load_res) res_q <= res_next;
    end
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic [1:0] flags_q;
  logic       carry_next;

  always_comb begin
    carry_next = 1'b0;
    case (op_q)
      OP_ADD:  carry_next = res_next[DATA_W];
      OP_SUB:  carry_next = (a_q < b_q);
      default: carry_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         flags_q <= 2'b00;
    else if (load_res) flags_q <= {carry_next, (res_next == '0)};
  end

  assign bus.flags = flags_q;
`endif

  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = res_q;
  assign fsm_state        = state;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table, hand-written corner
// sequences and random ops scored against an arithmetic reference model.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int DW = 3;
  localparam int RW = 2 * DW;

  logic   clk;
  logic   reset;
  state_e fsm_state;

  alu_exec_if #(.DATA_W(DW)) bus ();

  alu_exec #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [RW-1:0] exp_q[$];
  logic [1:0]    exp_flag_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] res;
    logic [1:0]    flg;
    int            lat;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: plain integer arithmetic on the operation's definition
  function automatic logic [RW-1:0] model_result(input logic [1:0] op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
    int unsigned ia, ib, r, m;
    ia = a;
    ib = b;
    m  = 1 << RW;
    case (op)
      2'b00:   r = ia + ib;
      2'b01:   r = ia + m - ib;
      2'b10:   r = ia * ib;
      default: r = ia & ib;
    endcase
    return RW'(r % m);
  endfunction

  function automatic logic [1:0] model_flags(input logic [1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    int unsigned ia, ib;
    logic        carry;
    ia = a;
    ib = b;
    carry = 1'b0;
    if (op == 2'b00) carry = ((ia + ib) >= (1 << DW));
    if (op == 2'b01) carry = (ia < ib);
    return {carry, (model_result(op, a, b) == '0)};
  endfunction

  // driver: issue one op, wait for the result, optionally stall ready,
  // score the result from the expected queue, then complete the handshake
  task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int delay, input bit scramble, input bit noise,
                        input int exp_lat, input string tag);
    int            lat;
    logic [RW-1:0] res;
    logic [RW-1:0] exp_res;
    bus.start   = 1'b1;
    bus.data_a  = a;
    bus.data_b  = b;
    bus.compute = op;
    tick();
    lat = 1;
    bus.start = noise;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (scramble || noise) begin
      bus.data_a  = ~a;
      bus.data_b  = ~b;
      bus.compute = ~op;
    end
    while (!bus.result_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    res = bus.result;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_scoreboard: got result %0d with no expected entry", tag, res);
    end else begin
      exp_res = exp_q.pop_front();
      check({tag, "_result"}, 32'(res), 32'(exp_res));
    end
`ifdef ALU_EXEC_FLAGS_EN
    if (exp_flag_q.size() != 0) check({tag, "_flags"}, 32'(bus.flags), 32'(exp_flag_q.pop_front()));
`endif
    for (int k = 0; k < delay; k++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(res));
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic expect_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_q.push_back(model_result(op, a, b));
    exp_flag_q.push_back(model_flags(op, a, b));
  endtask

  initial begin
    logic [1:0]    rop;
    logic [DW-1:0] ra, rb;

    vecs[0]  = '{2'b00, 3'd7, 3'd7, 6'd14, 2'b10, 2};
    vecs[1]  = '{2'b01, 3'd2, 3'd5, 6'd61, 2'b10, 2};
    vecs[2]  = '{2'b10, 3'd7, 3'd7, 6'd49, 2'b00, 4};
    vecs[3]  = '{2'b10, 3'd0, 3'd5, 6'd0,  2'b01, 4};
    vecs[4]  = '{2'b11, 3'd5, 3'd3, 6'd1,  2'b00, 2};
    vecs[5]  = '{2'b00, 3'd0, 3'd0, 6'd0,  2'b01, 2};
    vecs[6]  = '{2'b01, 3'd5, 3'd5, 6'd0,  2'b01, 2};
    vecs[7]  = '{2'b01, 3'd6, 3'd1, 6'd5,  2'b00, 2};
    vecs[8]  = '{2'b00, 3'd4, 3'd3, 6'd7,  2'b00, 2};
    vecs[9]  = '{2'b11, 3'd4, 3'd3, 6'd0,  2'b01, 2};
    vecs[10] = '{2'b10, 3'd7, 3'd1, 6'd7,  2'b00, 4};
    vecs[11] = '{2'b10, 3'd3, 3'd5, 6'd15, 2'b00, 4};
    vecs[12] = '{2'b00, 3'd6, 3'd5, 6'd11, 2'b10, 2};

    bus.start        = 1'b0;
    bus.data_a       = '0;
    bus.data_b       = '0;
    bus.compute      = 2'b00;
    bus.result_ready = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_state", 32'(fsm_state == IDLE), 32'd1);
`ifdef ALU_EXEC_FLAGS_EN
    check("rst_flags", 32'(bus.flags), 32'd0);
`endif

    // vector table
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i].res);
      exp_flag_q.push_back(vecs[i].flg);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, 1'b0, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // MUL with a second start held during the iterations: must be ignored
    exp_q.push_back(6'd49);
    exp_flag_q.push_back(2'b00);
    run_op(2'b10, 3'd7, 3'd7, 0, 1'b0, 1'b1, 4, "mul_ignore_start");
    tick();
    check("mul_ignore_idle", 32'(bus.busy), 32'd0);

    // AND with ready stalled 5 cycles while start is pulsed, then a start
    // in the first IDLE cycle after the handshake is accepted
    exp_q.push_back(6'd1);
    exp_flag_q.push_back(2'b00);
    run_op(2'b11, 3'd5, 3'd3, 5, 1'b0, 1'b1, 2, "and_stall");
    exp_q.push_back(6'd6);
    exp_flag_q.push_back(2'b00);
    run_op(2'b00, 3'd2, 3'd4, 0, 1'b0, 1'b0, 2, "b2b_add");

    // reset asserted during MUL iteration 1
    bus.start   = 1'b1;
    bus.data_a  = 3'd7;
    bus.data_b  = 3'd7;
    bus.compute = 2'b10;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_state", 32'(fsm_state == IDLE), 32'd1);
`ifdef ALU_EXEC_FLAGS_EN
    check("mid_rst_flags", 32'(bus.flags), 32'd0);
`endif
    tick();
    reset = 1'b0;
    exp_q.push_back(6'd7);
    exp_flag_q.push_back(2'b00);
    run_op(2'b00, 3'd3, 3'd4, 0, 1'b0, 1'b0, 2, "after_rst_add");

    // inputs changed right after start: latched values only
    exp_q.push_back(6'd5);
    exp_flag_q.push_back(2'b00);
    run_op(2'b00, 3'd2, 3'd3, 0, 1'b1, 1'b0, 2, "latch_add");
    exp_q.push_back(6'd12);
    exp_flag_q.push_back(2'b00);
    run_op(2'b10, 3'd6, 3'd2, 0, 1'b1, 1'b0, 4, "latch_mul");

    // random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = DW'($urandom_range(0, (1 << DW) - 1));
      rb  = DW'($urandom_range(0, (1 << DW) - 1));
      expect_op(rop, ra, rb);
      run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), (rop == 2'b10) ? DW + 1 : 2, $sformatf("rnd%0d", i));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
